// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the MEM stage.
// Accepts one lw/sw request at a time, holds the pipeline stall for the
// duration of the access and commits the read or write on the edge that
// enters DONE.
//
// Ports:
//   clk_i       - clock, all state changes on the rising edge
//   rst_i       - asynchronous active-low reset
//   MemRead_i   - load request
//   MemWrite_i  - store request
//   addr_i      - byte address (ALU result)
//   data_i      - store data (rs2)
//   data_o      - registered load result, held until the next read completes
//   stall_o     - combinational pipeline stall
//   err_o       - one-cycle pulse in DONE for an illegal access
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY) + 1;
  // Counter preload; only meaningful when LATENCY > 1.
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_data;
  logic            cap_wr;
  logic            cap_bad;

  logic [31:0]     mem [DEPTH];

  logic            req_c;
  logic            req_wr_c;
  logic            req_bad_c;
  logic            commit_c;
  logic [AW-1:0]   cm_idx_c;
  logic [31:0]     cm_data_c;
  logic            cm_wr_c;
  logic            cm_bad_c;

  // Request decode; a simultaneous read+write is treated as an illegal read.
  assign req_c     = MemRead_i | MemWrite_i;
  assign req_wr_c  = MemWrite_i & ~MemRead_i;
  assign req_bad_c = (addr_i[1:0] != 2'b00)
                   | ((addr_i >> (AW + 2)) != 32'd0)
                   | (MemRead_i & MemWrite_i);

  assign stall_o = ((state == IDLE) & req_c) | (state == BUSY);

  // Commit selection: with LATENCY=1 the access commits straight from the
  // live inputs on the accepting edge, otherwise from the captured request.
  always_comb begin
    commit_c  = 1'b0;
    cm_idx_c  = cap_idx;
    cm_data_c = cap_data;
    cm_wr_c   = cap_wr;
    cm_bad_c  = cap_bad;
    if ((state == IDLE) && req_c && (LATENCY == 1)) begin
      commit_c  = 1'b1;
      cm_idx_c  = addr_i[AW+1:2];
      cm_data_c = data_i;
      cm_wr_c   = req_wr_c;
      cm_bad_c  = req_bad_c;
    end else if ((state == BUSY) && (cnt == '0)) begin
      commit_c  = 1'b1;
    end
  end

  // FSM, request capture and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      data_o   <= '0;
      err_o    <= 1'b0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_wr   <= 1'b0;
      cap_bad  <= 1'b0;
    end else begin
      err_o <= commit_c & cm_bad_c;
      if (commit_c && !cm_wr_c) begin
        data_o <= cm_bad_c ? 32'd0 : mem[cm_idx_c];
      end
      case (state)
        IDLE: begin
          if (req_c) begin
            cap_idx  <= addr_i[AW+1:2];
            cap_data <= data_i;
            cap_wr   <= req_wr_c;
            cap_bad  <= req_bad_c;
            if (LATENCY == 1) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage array; not reset, written only by a legal committed store.
  always_ff @(posedge clk_i) begin
    if (commit_c && cm_wr_c && !cm_bad_c) begin
      mem[cm_idx_c] <= cm_data_c;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one LATENCY=4 instance and one
// LATENCY=1 instance, each with a reference memory model and a scoreboard.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd0, wr0, rd1, wr1;
  logic [31:0] addr, wdata;
  logic [31:0] dout0, dout1;
  logic        stall0, stall1, err0, err1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd0), .MemWrite_i(wr0),
    .addr_i(addr), .data_i(wdata), .data_o(dout0), .stall_o(stall0), .err_o(err0)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr), .data_i(wdata), .data_o(dout1), .stall_o(stall1), .err_o(err1)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [2][256];
  logic [31:0] last_data [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dout(input int sel);
    return (sel != 0) ? dout1 : dout0;
  endfunction

  function automatic logic stall(input int sel);
    return (sel != 0) ? stall1 : stall0;
  endfunction

  function automatic logic err(input int sel);
    return (sel != 0) ? err1 : err0;
  endfunction

  // One access: called just after a rising edge; holds the request through DONE.
  task automatic access(input int sel, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
    exp_t       e;
    bit         bad;
    int         n;
    int         lat;
    logic [7:0] idx;
    lat   = (sel != 0) ? 1 : 4;
    idx   = a[9:2];
    bad   = (a[1:0] != 2'b00) || (a >= 32'd1024) || (rd && wr);
    e.err = bad;
    if (rd) begin
      e.data = bad ? 32'd0 : model[sel][idx];
      last_data[sel] = e.data;
    end else begin
      e.data = last_data[sel];
      if (!bad) model[sel][idx] = d;
    end
    sb.push_back(e);
    addr  = a;
    wdata = d;
    if (sel != 0) begin rd1 = rd; wr1 = wr; end
    else          begin rd0 = rd; wr0 = wr; end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall(sel)) n++;
      else break;
    end
    check("stall_len", 32'(n), 32'(lat));
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("done_data", dout(sel), e.data);
      check("done_err", 32'(err(sel)), 32'(e.err));
    end
    @(posedge clk); #1;
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    check("err_pulse_end", 32'(err(sel)), 32'd0);
    check("stall_after", 32'(stall(sel)), 32'd0);
    check("data_hold", dout(sel), last_data[sel]);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0;
    rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    addr = '0; wdata = '0;
    last_data[0] = '0;
    last_data[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data0", dout0, 32'd0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_stall0", 32'(stall0), 32'd0);
    check("rst_data1", dout1, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Known contents at 0x10, then a store abandoned by reset mid-BUSY.
    access(0, 0, 1, 32'h10, 32'h1111_1111);
    access(0, 1, 0, 32'h10, 32'h0);
    addr = 32'h10; wdata = 32'hBADB_AD00; wr0 = 1'b1;
    @(negedge clk);
    check("rst_req_stall", 32'(stall0), 32'd1);
    @(posedge clk); #1;
    wr0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_data", dout0, 32'd0);
    check("midrst_err", 32'(err0), 32'd0);
    check("midrst_stall", 32'(stall0), 32'd0);
    last_data[0] = '0;
    last_data[1] = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 1, 0, 32'h10, 32'h0);

    // Store then load, illegal accesses, simultaneous read+write.
    access(0, 0, 1, 32'h40, 32'hDEAD_BEEF);
    access(0, 1, 0, 32'h40, 32'h0);
    access(0, 0, 1, 32'h41, 32'hCAFE_F00D);
    access(0, 1, 0, 32'h40, 32'h0);
    access(0, 1, 0, 32'h400, 32'h0);
    access(0, 1, 0, 32'h40, 32'h0);
    access(0, 1, 1, 32'h40, 32'h5555_5555);
    access(0, 1, 0, 32'h40, 32'h0);
    access(0, 1, 0, 32'h3FC, 32'h0);

    // Random legal write/read pairs.
    for (int k = 0; k < 6; k++) begin
      w = 32'($urandom_range(0, 255)) << 2;
      access(0, 0, 1, w, $urandom);
      access(0, 1, 0, w, 32'h0);
    end

    // Idle: outputs must stay put.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_stall", 32'(stall0), 32'd0);
      check("idle_err", 32'(err0), 32'd0);
      check("idle_data", dout0, last_data[0]);
    end
    @(posedge clk); #1;

    // LATENCY=1 instance.
    access(1, 0, 1, 32'h8, 32'h1234_5678);
    access(1, 1, 0, 32'h8, 32'h0);
    access(1, 1, 0, 32'h9, 32'h0);
    access(1, 1, 0, 32'h8, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
